// File: rtl/hitbox_collision_detector_if.sv
// Player-position / attack inputs and hit-registration results exchanged
// between the game logic (master) and the collision detector (slave).
interface hitbox_collision_detector_if #(
  parameter int COORD_W = 7
);
  logic               tick;
  logic [COORD_W-1:0] p1_x;
  logic [COORD_W-1:0] p1_y;
  logic [COORD_W-1:0] p2_x;
  logic [COORD_W-1:0] p2_y;
  logic               p1_attack;
  logic               p2_attack;
  logic               result_valid;
  logic               collision;
  logic               collision_rise;
  logic               p1_hit;
  logic               p2_hit;

  modport master (
    output tick, p1_x, p1_y, p2_x, p2_y, p1_attack, p2_attack,
    input  result_valid, collision, collision_rise, p1_hit, p2_hit
  );

  modport slave (
    input  tick, p1_x, p1_y, p2_x, p2_y, p1_attack, p2_attack,
    output result_valid, collision, collision_rise, p1_hit, p2_hit
  );
endinterface

// File: rtl/hitbox_collision_detector.sv
// Three-stage player-vs-player overlap detector with per-attacker hit cooldown.
// Radial (distance-squared) or box (AABB) overlap, selected by MODE.
module hitbox_collision_detector #(
  parameter int COORD_W  = 7,
  parameter int MODE     = 0,
  parameter int RADIUS   = 15,
  parameter int BOX_X    = 12,
  parameter int BOX_Y    = 20,
  parameter int COOLDOWN = 4
) (
  input logic clk,
  input logic rst_n,
  hitbox_collision_detector_if.slave bus
);

  localparam int SUM_W = 2 * COORD_W + 1;
  localparam int CD_W  = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [SUM_W-1:0]   RAD_SQ  = SUM_W'(RADIUS * RADIUS);
  localparam logic [COORD_W-1:0] BOX_X_C = COORD_W'(BOX_X);
  localparam logic [COORD_W-1:0] BOX_Y_C = COORD_W'(BOX_Y);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN);

  logic               s1_valid;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               s1_edge1;
  logic               s1_edge2;
  logic               prev1;
  logic               prev2;
  logic [COORD_W-1:0] dx_next;
  logic [COORD_W-1:0] dy_next;

  logic               s2_valid;
  logic               s2_overlap;
  logic               s2_edge1;
  logic               s2_edge2;
  logic [SUM_W-1:0]   dx_w;
  logic [SUM_W-1:0]   dy_w;
  logic [SUM_W-1:0]   sum;
  logic               overlap_next;

  logic               result_valid_q;
  logic               collision_q;
  logic               rise_q;
  logic               hit1_q;
  logic               hit2_q;
  logic [CD_W-1:0]    cd1;
  logic [CD_W-1:0]    cd2;
  logic               hit1_next;
  logic               hit2_next;

  // Compare before subtracting so the difference never wraps modulo 2^COORD_W.
  always_comb begin
    dx_next = (bus.p1_x >= bus.p2_x) ? (bus.p1_x - bus.p2_x) : (bus.p2_x - bus.p1_x);
    dy_next = (bus.p1_y >= bus.p2_y) ? (bus.p1_y - bus.p2_y) : (bus.p2_y - bus.p1_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      dx       <= '0;
      dy       <= '0;
      s1_edge1 <= 1'b0;
      s1_edge2 <= 1'b0;
      prev1    <= 1'b0;
      prev2    <= 1'b0;
    end else begin
      s1_valid <= bus.tick;
      if (bus.tick) begin
        dx       <= dx_next;
        dy       <= dy_next;
        s1_edge1 <= bus.p1_attack & ~prev1;
        s1_edge2 <= bus.p2_attack & ~prev2;
        prev1    <= bus.p1_attack;
        prev2    <= bus.p2_attack;
      end
    end
  end

  always_comb begin
    dx_w = SUM_W'(dx);
    dy_w = SUM_W'(dy);
    sum  = dx_w * dx_w + dy_w * dy_w;
    if (MODE == 0) overlap_next = (sum < RAD_SQ);
    else           overlap_next = (dx < BOX_X_C) && (dy < BOX_Y_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_overlap <= 1'b0;
      s2_edge1   <= 1'b0;
      s2_edge2   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_overlap <= overlap_next;
        s2_edge1   <= s1_edge1;
        s2_edge2   <= s1_edge2;
      end
    end
  end

  assign hit1_next = s2_overlap & s2_edge1 & (cd1 == '0);
  assign hit2_next = s2_overlap & s2_edge2 & (cd2 == '0);

  // Cooldowns count results, not clock cycles, so they only move with s2_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      collision_q    <= 1'b0;
      rise_q         <= 1'b0;
      hit1_q         <= 1'b0;
      hit2_q         <= 1'b0;
      cd1            <= '0;
      cd2            <= '0;
    end else begin
      result_valid_q <= s2_valid;
      rise_q         <= s2_valid & s2_overlap & ~collision_q;
      hit1_q         <= s2_valid & hit1_next;
      hit2_q         <= s2_valid & hit2_next;
      if (s2_valid) begin
        collision_q <= s2_overlap;
        if (hit1_next)        cd1 <= CD_LOAD;
        else if (cd1 != '0)   cd1 <= cd1 - CD_W'(1);
        if (hit2_next)        cd2 <= CD_LOAD;
        else if (cd2 != '0)   cd2 <= cd2 - CD_W'(1);
      end
    end
  end

  assign bus.result_valid   = result_valid_q;
  assign bus.collision      = collision_q;
  assign bus.collision_rise = rise_q;
  assign bus.p1_hit         = hit1_q;
  assign bus.p2_hit         = hit2_q;

endmodule
